// File: rtl/id_operand_stage.sv
// Decode-operand stage: flop register file, priority operand forwarding, load-use stall
// and a registered ID/EX slot. Optional same-cycle write-back bypass: define ID_WB_BYPASS_EN.
module id_operand_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FWD_SRCS   = 2,
    parameter int CTRL_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [REG_ADDR_W-1:0]          in_rs1,
    input  logic [REG_ADDR_W-1:0]          in_rs2,
    input  logic [REG_ADDR_W-1:0]          in_rd,
    input  logic                           in_rd_we,
    input  logic [CTRL_W-1:0]              in_ctrl,
    input  logic [FWD_SRCS-1:0]            fwd_valid,
    input  logic [FWD_SRCS-1:0]            fwd_avail,
    input  logic [FWD_SRCS*REG_ADDR_W-1:0] fwd_reg,
    input  logic [FWD_SRCS*DATA_W-1:0]     fwd_data,
    input  logic                           wb_we,
    input  logic [REG_ADDR_W-1:0]          wb_reg,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_src1,
    output logic [DATA_W-1:0]              out_src2,
    output logic [REG_ADDR_W-1:0]          out_rd,
    output logic                           out_rd_we,
    output logic [CTRL_W-1:0]              out_ctrl
);

    localparam int NREGS = 2**REG_ADDR_W;

    typedef enum logic {EMPTY, FULL} slotState_t;

    logic [DATA_W-1:0]     r_regs [NREGS];
    slotState_t            r_state;
    logic [DATA_W-1:0]     r_src1;
    logic [DATA_W-1:0]     r_src2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_rdWe;
    logic [CTRL_W-1:0]     r_ctrl;

    logic [REG_ADDR_W-1:0] w_rs [2];
    logic [DATA_W-1:0]     w_opnd [2];
    logic [1:0]            w_opHaz;
    logic                  w_hazard;
    logic                  w_accept;

    assign w_rs[0] = in_rs1;
    assign w_rs[1] = in_rs2;

    // Oldest source is scanned first so the youngest match overwrites it and wins.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_opnd[s]  = r_regs[w_rs[s]];
            w_opHaz[s] = 1'b0;
`ifdef ID_WB_BYPASS_EN
            if (wb_we && wb_reg == w_rs[s]) begin
                w_opnd[s] = wb_data;
            end
`endif
            for (int i = FWD_SRCS-1; i >= 0; i--) begin
                if (fwd_valid[i] && fwd_reg[i*REG_ADDR_W +: REG_ADDR_W] == w_rs[s]) begin
                    w_opnd[s]  = fwd_data[i*DATA_W +: DATA_W];
                    w_opHaz[s] = !fwd_avail[i];
                end
            end
            if (w_rs[s] == '0) begin
                w_opnd[s]  = '0;
                w_opHaz[s] = 1'b0;
            end
        end
    end

    assign w_hazard = in_valid && (|w_opHaz);
    assign in_ready = !rst && (flush || (!w_hazard && (r_state == EMPTY || out_ready)));
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '{default: '0};
        end else if (wb_we && wb_reg != '0) begin
            r_regs[wb_reg] <= wb_data;
        end
    end

    // Output slot; the payload only moves on accept, so a stalled FULL slot holds still.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_src1  <= '0;
            r_src2  <= '0;
            r_rd    <= '0;
            r_rdWe  <= 1'b0;
            r_ctrl  <= '0;
        end else if (flush) begin
            r_state <= EMPTY;
        end else if (w_accept) begin
            r_state <= FULL;
            r_src1  <= w_opnd[0];
            r_src2  <= w_opnd[1];
            r_rd    <= in_rd;
            r_rdWe  <= in_rd_we;
            r_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            r_state <= EMPTY;
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_src1  = r_src1;
    assign out_src2  = r_src2;
    assign out_rd    = r_rd;
    assign out_rd_we = r_rdWe;
    assign out_ctrl  = r_ctrl;

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomised and directed bench for id_operand_stage against an in-bench reference model.
// The model follows ID_WB_BYPASS_EN the same way the design does.
module tb_id_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 2;
    localparam int CW = 16;
`ifdef ID_WB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [AW-1:0] in_rd;
    logic          in_rd_we;
    logic [CW-1:0] in_ctrl;
    logic [NF-1:0] fwd_valid;
    logic [NF-1:0] fwd_avail;
    logic [NF*AW-1:0] fwd_reg;
    logic [NF*DW-1:0] fwd_data;
    logic          wb_we;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_src1;
    logic [DW-1:0] out_src2;
    logic [AW-1:0] out_rd;
    logic          out_rd_we;
    logic [CW-1:0] out_ctrl;

    id_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .FWD_SRCS(NF), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_ctrl(in_ctrl), .fwd_valid(fwd_valid), .fwd_avail(fwd_avail),
        .fwd_reg(fwd_reg), .fwd_data(fwd_data), .wb_we(wb_we), .wb_reg(wb_reg),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_ctrl(out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model: architectural register values and the expected ID/EX slot.
    logic [DW-1:0] mRegs [32];
    logic          mValid;
    logic [DW-1:0] mSrc1;
    logic [DW-1:0] mSrc2;
    logic [AW-1:0] mRd;
    logic          mRdWe;
    logic [CW-1:0] mCtrl;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // First matching source in priority order decides; r0 is hard zero.
    function automatic void resolveOp(input logic [AW-1:0] rs, output logic haz, output logic [DW-1:0] val);
        haz = 1'b0;
        val = mRegs[rs];
        if (BYPASS && wb_we && wb_reg == rs) val = wb_data;
        for (int i = 0; i < NF; i++) begin
            if (fwd_valid[i] && fwd_reg[i*AW +: AW] == rs) begin
                haz = !fwd_avail[i];
                val = fwd_data[i*DW +: DW];
                break;
            end
        end
        if (rs == 0) begin
            haz = 1'b0;
            val = '0;
        end
    endfunction

    // Runs one clock with the currently driven inputs and checks against the model.
    task automatic applyStimulus();
        logic          h1, h2, expReady, acc, wasRst;
        logic [DW-1:0] v1, v2;
        #3;
        resolveOp(in_rs1, h1, v1);
        resolveOp(in_rs2, h2, v2);
        if (rst)        expReady = 1'b0;
        else if (flush) expReady = 1'b1;
        else            expReady = !(in_valid && (h1 || h2)) && (!mValid || out_ready);
        checkOutput("in_ready", in_ready, expReady);
        acc    = in_valid && expReady && !flush && !rst;
        wasRst = rst;
        @(posedge clk);
        if (rst) begin
            mValid = 1'b0;
            mSrc1 = '0; mSrc2 = '0; mRd = '0; mRdWe = 1'b0; mCtrl = '0;
            for (int r = 0; r < 32; r++) mRegs[r] = '0;
        end else begin
            if (flush) mValid = 1'b0;
            else if (acc) begin
                mValid = 1'b1;
                mSrc1 = v1; mSrc2 = v2; mRd = in_rd; mRdWe = in_rd_we; mCtrl = in_ctrl;
            end else if (out_ready) mValid = 1'b0;
            if (wb_we && wb_reg != 0) mRegs[wb_reg] = wb_data;
        end
        #1;
        checkOutput("out_valid", out_valid, mValid);
        if (mValid || wasRst) begin
            checkOutput("out_src1", out_src1, mSrc1);
            checkOutput("out_src2", out_src2, mSrc2);
            checkOutput("out_rd", out_rd, mRd);
            checkOutput("out_rd_we", out_rd_we, mRdWe);
            checkOutput("out_ctrl", out_ctrl, mCtrl);
        end
    endtask

    task automatic clearInputs();
        rst = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_ctrl = 0;
        fwd_valid = 0; fwd_avail = 0; fwd_reg = 0; fwd_data = 0;
        wb_we = 0; wb_reg = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mRegs[r] = '0;
        mValid = 0; mSrc1 = 0; mSrc2 = 0; mRd = 0; mRdWe = 0; mCtrl = 0;
        clearInputs();
        rst = 1;
        #1;
        applyStimulus();
        applyStimulus();
        rst = 0;
        checkOutput("rstValid", out_valid, 1'b0);

        $display("[TB] reading r1..r31 after reset");
        for (int r = 1; r < 32; r++) begin
            in_valid = 1; in_rs1 = AW'(r); in_rs2 = AW'(32 - r); in_rd = AW'(r); in_rd_we = 1;
            in_ctrl = CW'(r);
            applyStimulus();
            checkOutput("regZero", {out_src1, out_src2}, 64'h0);
        end

        in_valid = 0; wb_we = 1; wb_reg = 0; wb_data = 5;
        applyStimulus();
        wb_we = 0; in_valid = 1; in_rs1 = 0; in_rs2 = 0;
        applyStimulus();
        checkOutput("r0Write", out_src1, 0);

        $display("[TB] write-back collision");
        wb_we = 1; wb_reg = 3; wb_data = 32'hDEAD; in_rs1 = 3; in_rs2 = 0;
        applyStimulus();
        checkOutput("wbBypass", out_src1, BYPASS ? 32'hDEAD : 32'h0);
        wb_we = 0;

        $display("[TB] forwarding priority");
        fwd_valid = 2'b11; fwd_avail = 2'b11; fwd_reg = {5'd7, 5'd7};
        fwd_data = {32'h22, 32'h11}; in_rs1 = 7; in_rs2 = 3;
        applyStimulus();
        checkOutput("fwdPrio", out_src1, 32'h11);

        $display("[TB] load-use stall");
        fwd_valid = 2'b01; fwd_avail = 2'b00; fwd_reg = {5'd0, 5'd4}; fwd_data = 64'h99;
        in_rs1 = 0; in_rs2 = 4; in_ctrl = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("luStall", in_ready, 1'b0);
            applyStimulus();
        end
        fwd_avail = 2'b01;
        applyStimulus();
        checkOutput("luValue", out_src2, 32'h99);
        checkOutput("luValid", out_valid, 1'b1);
        fwd_valid = 0;

        $display("[TB] backpressure");
        in_ctrl = 16'hAAAA; in_rs2 = 0;
        applyStimulus();
        in_ctrl = 16'h5555; out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("bpHold", out_ctrl, 16'hAAAA);
        end
        out_ready = 1;
        applyStimulus();
        checkOutput("bpNext", out_ctrl, 16'h5555);

        $display("[TB] flush and reset mid-stall");
        out_ready = 0; flush = 1; in_ctrl = 16'h7777;
        applyStimulus();
        checkOutput("flushValid", out_valid, 1'b0);
        flush = 0; out_ready = 1;
        fwd_valid = 2'b01; fwd_avail = 2'b00; fwd_reg = {5'd0, 5'd4}; in_rs2 = 4;
        applyStimulus();
        rst = 1;
        applyStimulus();
        checkOutput("rstStall", out_valid, 1'b0);
        clearInputs();
        applyStimulus();

        $display("[TB] random phase");
        for (int c = 0; c < 500; c++) begin
            rst       = ($urandom % 64) == 0;
            flush     = ($urandom % 16) == 0;
            in_valid  = ($urandom % 4) != 0;
            in_rs1    = AW'($urandom_range(0, 7));
            in_rs2    = AW'($urandom_range(0, 7));
            in_rd     = AW'($urandom);
            in_rd_we  = 1'($urandom);
            in_ctrl   = CW'($urandom);
            fwd_valid = NF'($urandom);
            fwd_avail = {1'(($urandom % 3) != 0), 1'(($urandom % 3) != 0)};
            fwd_reg   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            fwd_data  = {32'($urandom), 32'($urandom)};
            wb_we     = 1'($urandom);
            wb_reg    = AW'($urandom_range(0, 7));
            wb_data   = 32'($urandom);
            out_ready = ($urandom % 4) != 0;
            applyStimulus();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised decode-operand stage between the IF/ID and ID/EX registers of the Scipio pipeline. It holds a flop-based register file and resolves operand values with priority forwarding from a configurable number of downstream stages. It detects load-use hazards and stalls upstream, then registers the resolved operands into an ID/EX output slot with a valid/ready handshake. It replaces the fixed two-source, unclocked forwarding of the previous ID stage.

## Interface

Parameters:
- DATA_W, 32, operand/register width
- REG_ADDR_W, 5, register index width; register count is 2**REG_ADDR_W
- FWD_SRCS, 2, number of forwarding sources; index 0 is youngest (EX), index 1 is MEM, and so on
- CTRL_W, 16, width of decoded control bundle passed through to EX

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  REG_ADDR_W  source register indices
- in_rd  in  REG_ADDR_W  destination index
- in_rd_we  in  1  instruction writes in_rd
- in_ctrl  in  CTRL_W  opaque control bundle
- fwd_valid  in  FWD_SRCS  source i holds an instruction writing fwd_reg[i]
- fwd_avail  in  FWD_SRCS  source i's data is already computed (0 for a load in EX)
- fwd_reg  in  FWD_SRCS*REG_ADDR_W  destination index per source, source i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- fwd_data  in  FWD_SRCS*DATA_W  result per source, same packing
- wb_we, wb_reg, wb_data  in  1 / REG_ADDR_W / DATA_W  write-back port
- flush  in  1  squash ID and ID/EX contents
- out_valid  out  1  ID/EX slot holds an instruction
- out_ready  in  1  EX accepts slot this cycle
- out_src1, out_src2  out  DATA_W  resolved operands
- out_rd, out_rd_we, out_ctrl  out  pass-through of accepted instruction

## Operation

- Register file: one write port and two combinational read ports. Register 0 always reads 0, and writes to it are ignored.
- Operand resolution for each rsN:
  - If rsN == 0, the operand is 0.
  - Otherwise take the lowest index i with fwd_valid[i] && fwd_reg[i]==rsN.
  - If that i has fwd_avail[i] = 1, use fwd_data[i].
  - If that i has fwd_avail[i] = 0, raise a hazard.
  - If no source matches, use the write-back bypass (see Configuration), else the register file.
- Only the highest-priority matching source is considered. A stale older match never overrides it.
- hazard = in_valid && (rs1 hazard || rs2 hazard).
- in_ready = !hazard && (!out_valid || out_ready). While flush is high, in_ready = 1 and the input is dropped.
- Accept = in_valid && in_ready && !flush. Accept loads the output slot with the resolved operands, rd, rd_we and ctrl.
- Output slot state is {EMPTY, FULL}:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out_ready without accept.
  - FULL→FULL on out_ready with accept, or when held.
  - Any state→EMPTY on flush.
- While FULL && !out_ready, all out_* are held stable.
- Write-back always updates the register file, independent of stall or flush.

## Timing

- Latency: one cycle from accept to out_valid.
- Hazard stall: in_ready drops combinationally in the cycle the hazard exists. The cycle after the source asserts fwd_avail, the instruction is accepted with the forwarded value.
- Flush and accept in the same cycle: flush wins, and out_valid = 0 next cycle.
- Reset: out_valid = 0, out_src1 = out_src2 = 0, out_rd = 0, out_rd_we = 0, out_ctrl = 0, and all registers = 0.
- Reset asserted mid-stall discards the pending instruction. in_ready is 0 while rst is high.

## Configuration

- ID_WB_BYPASS_EN defined:
  - If wb_we && wb_reg==rsN && rsN!=0 and no forwarding source matches, the operand is wb_data in the same cycle (write-before-read).
- ID_WB_BYPASS_EN undefined:
  - The read returns the pre-write register value.
  - The pipeline must then present WB as the oldest forwarding source.

## Test plan

- Reset, then read r1..r31 with no forwarding → out_src1 = out_src2 = 0. Writing 5 to r0 via WB, then reading r0 → 0.
- WB writes r3 = 0xDEAD and an instruction reading rs1 = r3 is accepted in the same cycle:
  - With ID_WB_BYPASS_EN → out_src1 = 0xDEAD.
  - Without it → 0.
- Both sources match: fwd_valid = 2'b11, fwd_reg = {r7, r7}, data = {0x22 (MEM), 0x11 (EX)}, rs1 = r7 → out_src1 = 0x11.
- Load-use: EX fwd_reg = r4 with fwd_avail = 0, rs2 = r4 → in_ready = 0 for exactly as many cycles as fwd_avail stays low. On the cycle after fwd_avail = 1 with data 0x99, the instruction is accepted and out_src2 = 0x99.
- Backpressure: out_ready = 0 for 3 cycles while FULL → outputs unchanged and in_ready = 0. Then out_ready = 1 → the next instruction appears one cycle later.
- Flush with in_valid = 1 and the slot FULL → out_valid = 0 next cycle and the instruction is not captured. A synchronous rst pulse mid-stall → out_valid = 0 next cycle.
